// File: rtl/lift_pkg.sv
// Shared types and display constants for the parametrised lift controller.
package lift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVING,
    ST_DOOR_OPEN
  } state_e;

  // Motion glyphs, active-low, bit6=g .. bit0=a
  localparam logic [6:0] HEX_UP   = 7'b1111110;
  localparam logic [6:0] HEX_DOWN = 7'b1110111;
  localparam logic [6:0] HEX_STOP = 7'b0111111;

  // Hex digit patterns, index 15 leftmost
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

endpackage

// File: rtl/lift_controller_if.sv
// Switch/indicator bundle between the board top level and the lift controller.
interface lift_controller_if #(
  parameter int FLOORS = 4
);
  localparam int FLOOR_W = $clog2(FLOORS);

  logic [FLOORS-1:0]  sw;
  logic [FLOOR_W-1:0] floor;
  logic [FLOORS-1:0]  pending;
  logic               dir_up;
  logic               moving;
  logic               LED_GREEN;
  logic               LED_RED;
  logic [6:0]         HEX0;
  logic [6:0]         HEX1;

  modport master (
    output sw,
    input  floor, pending, dir_up, moving, LED_GREEN, LED_RED, HEX0, HEX1
  );

  modport slave (
    input  sw,
    output floor, pending, dir_up, moving, LED_GREEN, LED_RED, HEX0, HEX1
  );
endinterface

// File: rtl/seg7_hex.sv
// 4-bit value to active-low seven-segment pattern.
module seg7_hex
  import lift_pkg::*;
(
  input  logic [3:0] i_val,
  output logic [6:0] o_seg
);
  assign o_seg = SEG_TABLE[i_val];
endmodule

// File: rtl/lift_controller.sv
// SCAN-scheduled elevator: latches floor calls, times travel and door dwell,
// drives door LEDs and floor/motion seven-segment displays.
module lift_controller
  import lift_pkg::*;
#(
  parameter int FLOORS        = 4,
  parameter int TRAVEL_CYCLES = 50_000_000,
  parameter int DOOR_CYCLES   = 100_000_000
) (
  input logic        clk,
  input logic        res,
  lift_controller_if.slave bus
);
  localparam int FLOOR_W = $clog2(FLOORS);
  localparam int CNT_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);

  state_e             r_state;
  logic [FLOOR_W-1:0] r_floor;
  logic [FLOORS-1:0]  r_pending;
  logic               r_dir_up;
  logic               r_moving;
  logic               r_door;
  logic [CNT_W-1:0]   r_cnt;

  logic [FLOORS-1:0]  w_req;
  logic [FLOORS-1:0]  w_above, w_below, w_next_above, w_next_below;
  logic [FLOORS-1:0]  w_clear;
  logic [FLOOR_W-1:0] w_next_floor;
  logic               w_ahead_up, w_ahead_down, w_here, w_go_up;
  logic               w_next_here, w_next_ahead, w_arrive;
  logic [6:0]         w_hex0;

  // Requests seen this cycle include calls arriving on the switches right now
  always_comb begin
    w_req        = r_pending | bus.sw;
    w_next_floor = r_dir_up ? r_floor + FLOOR_W'(1) : r_floor - FLOOR_W'(1);
    for (int i = 0; i < FLOORS; i++) begin
      w_above[i]      = (i > int'(r_floor));
      w_below[i]      = (i < int'(r_floor));
      w_next_above[i] = (i > int'(w_next_floor));
      w_next_below[i] = (i < int'(w_next_floor));
    end
    w_ahead_up   = |(w_req & w_above);
    w_ahead_down = |(w_req & w_below);
    w_here       = w_req[r_floor];
    w_go_up      = r_dir_up ? w_ahead_up : !w_ahead_down;
    w_next_here  = w_req[w_next_floor];
    w_next_ahead = r_dir_up ? |(w_req & w_next_above) : |(w_req & w_next_below);
    w_arrive     = (r_state == ST_MOVING) && (r_cnt == TRAVEL_LAST);

    // The floor where the door can open is served, never latched
    w_clear = '0;
    if (r_state != ST_MOVING)
      w_clear = FLOORS'(1) << r_floor;
    else if (w_arrive && w_next_here)
      w_clear = FLOORS'(1) << w_next_floor;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state   <= ST_IDLE;
      r_floor   <= '0;
      r_pending <= '0;
      r_dir_up  <= 1'b1;
      r_moving  <= 1'b0;
      r_door    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_pending <= w_req & ~w_clear;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_here) begin
            r_state <= ST_DOOR_OPEN;
            r_door  <= 1'b1;
          end else if (w_ahead_up || w_ahead_down) begin
            r_state  <= ST_MOVING;
            r_moving <= 1'b1;
            r_dir_up <= w_go_up;
          end
        end
        ST_MOVING: begin
          if (w_arrive) begin
            r_floor <= w_next_floor;
            r_cnt   <= '0;
            if (w_next_here) begin
              r_state  <= ST_DOOR_OPEN;
              r_moving <= 1'b0;
              r_door   <= 1'b1;
            end else if (!w_next_ahead) begin
              r_state  <= ST_IDLE;
              r_moving <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DOOR_OPEN: begin
          // A call at this floor holds the door by restarting the dwell
          if (bus.sw[r_floor]) begin
            r_cnt <= '0;
          end else if (r_cnt == DOOR_LAST) begin
            r_state <= ST_IDLE;
            r_door  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_moving <= 1'b0;
          r_door   <= 1'b0;
          r_cnt    <= '0;
        end
      endcase
    end
  end

  seg7_hex u_hex0 (
    .i_val (4'(r_floor)),
    .o_seg (w_hex0)
  );

  assign bus.floor     = r_floor;
  assign bus.pending   = r_pending;
  assign bus.dir_up    = r_dir_up;
  assign bus.moving    = r_moving;
  assign bus.LED_GREEN = r_door;
  assign bus.LED_RED   = ~r_door;
  assign bus.HEX0      = w_hex0;
  assign bus.HEX1      = !r_moving ? HEX_STOP : (r_dir_up ? HEX_UP : HEX_DOWN);

endmodule

// File: doc/lift_controller.md
# lift_controller

Parametrised elevator controller: the next generation of the board-level lift block, supporting FLOORS floors instead of a fixed set. It latches floor calls from the switches, schedules them with a SCAN (elevator) policy, times floor-to-floor travel and door dwell, and drives the door LEDs and two seven-segment displays (current floor, motion). It sits directly under the board top level, between the switch inputs and the LED/HEX outputs.

## Interface
- FLOORS, 4, number of floors, 2..16 (one hex digit).
- FLOOR_W, $clog2(FLOORS), floor index width (derived, not overridden).
- TRAVEL_CYCLES, 50_000_000, clock cycles per one-floor move, ≥1.
- DOOR_CYCLES, 100_000_000, clock cycles the door stays open, ≥1.
- clk  in  1  system clock, all state on rising edge.
- res  in  1  asynchronous, active-low reset.
- sw  in  FLOORS  floor call per floor, level-sensitive, sampled every cycle.
- floor  out  FLOOR_W  current floor index.
- pending  out  FLOORS  latched, not-yet-served calls.
- dir_up  out  1  current/last travel direction (1 = up).
- moving  out  1  cabin travelling.
- LED_GREEN  out  1  door open.
- LED_RED  out  1  door closed (always ~LED_GREEN).
- HEX0  out  7  floor digit, active-low, bit6=g … bit0=a.
- HEX1  out  7  motion glyph, active-low, same bit order.

## Operation
- Reset (res=0, asynchronous): state IDLE, floor=0, pending=0, dir_up=1, moving=0, LED_GREEN=0, LED_RED=1, counter=0, HEX0=7'b1000000 ('0'), HEX1=7'b0111111.
- Call latching: pending[i] <= 1 when sw[i]=1, except when i==floor and state is IDLE or DOOR_OPEN (served immediately, never latched). Calls are never cancelled; only serving clears a bit.
- States: IDLE, MOVING, DOOR_OPEN.
- IDLE: if sw/pending at current floor → DOOR_OPEN. Else direction choice: keep dir_up if any pending strictly ahead in that direction; else reverse if any pending behind; else stay IDLE. Chosen direction → MOVING.
- MOVING: counter counts 0..TRAVEL_CYCLES-1; at terminal count floor ±1, counter=0. If pending[new floor] → DOOR_OPEN, bit cleared on same edge. Else if pending still ahead → stay MOVING. Else → IDLE.
- DOOR_OPEN: counter counts 0..DOOR_CYCLES-1, then → IDLE. sw at current floor during DOOR_OPEN restarts counter to 0 (door hold).
- Calls at the floor being left while MOVING are latched and served on the return sweep.
- Boundary: floor never exceeds FLOORS-1 or goes below 0; at end floors direction flips only through IDLE.
- HEX0: hex digit 0..F of floor. HEX1: up = only a lit (7'b1111110), down = only d lit (7'b1110111), not moving = only g lit (7'b0111111).

## Timing
- All outputs registered or decoded from registers; no combinational path sw → outputs.
- Call latency: sw high at edge n → pending visible after edge n.
- IDLE decision: one cycle; MOVING asserted the edge after a call is seen in IDLE.
- Per floor: exactly TRAVEL_CYCLES cycles in MOVING; door open exactly DOOR_CYCLES cycles (absent hold).
- DOOR_OPEN entry and pending-bit clear occur on the same edge as arrival.
- Reset mid-move: cabin returns to floor 0 immediately (logical reset; no travel).

## Structure
- Package lift_pkg: state enum (IDLE, MOVING, DOOR_OPEN), HEX motion glyph constants, hex digit table.
- Sub-module seg7_hex: 4-bit value → 7-bit active-low pattern, instantiated for HEX0.
- Ahead/behind detection as masked OR-reductions of pending against floor, in the top module.

## Test plan
- FLOORS=4, TRAVEL_CYCLES=4, DOOR_CYCLES=3 for all directed tests.
- Reset: hold res=0 → floor=0, pending=0, LED_RED=1, HEX0=7'b1000000, HEX1=7'b0111111.
- From floor 0 IDLE, pulse sw=4'b0100 one cycle → MOVING next edge, HEX1=7'b1111110, floor=2 after 8 MOVING cycles, LED_GREEN high 3 cycles, then IDLE, pending=0.
- SCAN: at floor 1 moving up, pending=4'b1001 → serves floor 3 first, then reverses, HEX1=7'b1110111, serves floor 0.
- Door hold: during DOOR_OPEN at floor 2, sw[2]=1 on 2nd door cycle → door stays open 3 further cycles, pending[2] stays 0.
- Async reset mid-move between floors 1 and 2 → all outputs to reset values without waiting for a clock edge.
